// File: rtl/point_pkg.sv
// Shared types and defaults for the laser-point scan controller.
//   psc_state_t : frame sequencer states
//   run_t       : one horizontal run of hit pixels (left edge, width, line index)
//   X_W / Y_W   : coordinate widths; run_t is built on these
package point_pkg;

    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned X_W          = 10;
    localparam int unsigned Y_W          = 9;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        REPORT = 2'd2
    } psc_state_t;

    typedef struct packed {
        logic [X_W-1:0] left;
        logic [X_W-1:0] width;
        logic [Y_W-1:0] y;
    } run_t;

endpackage

// File: rtl/psc_run_tracker.sv
// Per-line run tracker: opens a run on the first hit pixel, extends it on
// consecutive hits and closes it on a non-hit pixel, on a line start, or on
// the last active pixel of the line (that pixel included).
// Ports:
//   clk, rst  : pixel clock, asynchronous active-low reset
//   pix_go    : valid, in-range pixel this cycle
//   line_evt  : accepted pixel carries a line (or frame) start
//   restart   : accepted pixel carries a frame start; any open run is dropped
//   hit       : pixel is point-coloured
//   x, y      : coordinates of the current pixel
//   close     : strobe, a run finished this cycle (combinational)
//   run       : the finished run, valid with close
module psc_run_tracker
    import point_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           pix_go,
    input  logic           line_evt,
    input  logic           restart,
    input  logic           hit,
    input  logic [X_W-1:0] x,
    input  logic [Y_W-1:0] y,
    output logic           close,
    output run_t           run
);

    logic           open_q, open_d;
    run_t           cur_q, cur_d;
    logic           live;
    logic           at_end;
    logic [X_W-1:0] width_inc;

    always_comb begin
        // An open run continues into this pixel only within the same line.
        live      = open_q && !restart && !line_evt;
        at_end    = (x == X_W'(H_ACTIVE - 1));
        width_inc = (cur_q.width >= X_W'(H_ACTIVE)) ? cur_q.width : cur_q.width + 1'b1;
        open_d    = open_q;
        cur_d     = cur_q;
        close     = 1'b0;
        run       = cur_q;

        if (restart) begin
            open_d = 1'b0;
        end

        // Previous run ends on a line boundary or a non-hit pixel.
        if (open_q && !restart && (line_evt || (pix_go && !hit))) begin
            close  = 1'b1;
            run    = cur_q;
            open_d = 1'b0;
        end

        if (pix_go && hit) begin
            if (live) begin
                cur_d.width = width_inc;
            end else begin
                cur_d.left  = x;
                cur_d.width = X_W'(1);
                cur_d.y     = y;
            end
            if (at_end) begin
                // Last pixel of the line closes the run including itself.
                close  = 1'b1;
                run    = cur_d;
                open_d = 1'b0;
            end else begin
                open_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            open_q <= 1'b0;
            cur_q  <= '0;
        end else begin
            open_q <= open_d;
            cur_q  <= cur_d;
        end
    end

endmodule

// File: rtl/point_scan_ctrl.sv
// Frame-level sequencer for laser-point detection. Counts pixel x/y, tracks
// the widest qualifying run of hit pixels in the frame and reports its centre
// on a valid/ready handshake once per frame.
// Ports:
//   clk, rst       : pixel clock, asynchronous active-low reset
//   i_frame_start  : first pixel of frame (implies line start)
//   i_line_start   : first pixel of each line
//   i_pix_valid    : pixel qualifier
//   i_pix_hit      : thresholded pixel is point-coloured
//   o_valid/i_ready: report handshake
//   o_found        : a qualifying run existed
//   o_centerX/Y    : centre of the widest run (0 when not found)
//   o_busy         : sequencer not idle
// Build option: PSC_SMOOTH_EN averages each found centre with the previously
// reported found centre.
module point_scan_ctrl
    import point_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = H_ACTIVE_DEF,
    parameter int unsigned V_ACTIVE  = V_ACTIVE_DEF,
    parameter int unsigned MIN_WIDTH = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_frame_start,
    input  logic           i_line_start,
    input  logic           i_pix_valid,
    input  logic           i_pix_hit,
    output logic           o_valid,
    input  logic           i_ready,
    output logic           o_found,
    output logic [X_W-1:0] o_centerX,
    output logic [Y_W-1:0] o_centerY,
    output logic           o_busy
);

    psc_state_t     state_q, state_d;
    logic [X_W-1:0] x_q, x_d, pix_x;
    logic [Y_W-1:0] y_q, y_d, pix_y, y_inc;
    run_t           best_q, best_d;
    logic           accept, fs, line_evt, pix_go, last_pix;
    logic           close;
    run_t           run;
    logic           found;
    logic [X_W-1:0] raw_x, rep_x;
    logic [Y_W-1:0] raw_y, rep_y;
    logic           handshake;

    always_comb begin
        // Frame start is only honoured from IDLE or SCAN; REPORT drops it.
        accept   = i_pix_valid && ((state_q == SCAN) || ((state_q == IDLE) && i_frame_start));
        fs       = accept && i_frame_start;
        line_evt = accept && (i_line_start || i_frame_start);
        y_inc    = (y_q >= Y_W'(V_ACTIVE)) ? y_q : y_q + 1'b1;
        pix_x    = line_evt ? '0 : x_q;
        pix_y    = fs ? '0 : (line_evt ? y_inc : y_q);
        pix_go   = accept && (pix_x < X_W'(H_ACTIVE)) && (pix_y < Y_W'(V_ACTIVE));
        last_pix = pix_go && (pix_x == X_W'(H_ACTIVE - 1)) && (pix_y == Y_W'(V_ACTIVE - 1));

        x_d = x_q;
        y_d = y_q;
        if (accept) begin
            x_d = (pix_x >= X_W'(H_ACTIVE)) ? pix_x : pix_x + 1'b1;
            y_d = pix_y;
        end

        state_d = state_q;
        if (accept) begin
            state_d = last_pix ? REPORT : SCAN;
        end else if ((state_q == REPORT) && i_ready) begin
            state_d = IDLE;
        end

        best_d = best_q;
        if (fs) begin
            best_d = '0;
        end else if (close && (run.width >= X_W'(MIN_WIDTH)) && (run.width > best_q.width)) begin
            best_d = run;
        end
    end

    psc_run_tracker #(
        .H_ACTIVE(H_ACTIVE)
    ) u_tracker (
        .clk     (clk),
        .rst     (rst),
        .pix_go  (pix_go),
        .line_evt(line_evt),
        .restart (fs),
        .hit     (i_pix_hit),
        .x       (pix_x),
        .y       (pix_y),
        .close   (close),
        .run     (run)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            best_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            best_q  <= best_d;
        end
    end

    assign found     = (best_q.width != '0);
    assign raw_x     = best_q.left + (best_q.width >> 1);
    assign raw_y     = best_q.y;
    assign handshake = (state_q == REPORT) && i_ready;

`ifdef PSC_SMOOTH_EN
    logic           hist_q;
    logic [X_W-1:0] hx_q;
    logic [Y_W-1:0] hy_q;

    always_comb begin
        rep_x = raw_x;
        rep_y = raw_y;
        if (hist_q) begin
            rep_x = X_W'(({1'b0, hx_q} + {1'b0, raw_x}) >> 1);
            rep_y = Y_W'(({1'b0, hy_q} + {1'b0, raw_y}) >> 1);
        end
    end

    // History tracks what was actually reported, and only for found frames.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_q <= 1'b0;
            hx_q   <= '0;
            hy_q   <= '0;
        end else if (handshake && found) begin
            hist_q <= 1'b1;
            hx_q   <= rep_x;
            hy_q   <= rep_y;
        end
    end
`else
    always_comb begin
        rep_x = raw_x;
        rep_y = raw_y;
    end
`endif

    always_comb begin
        o_valid   = (state_q == REPORT);
        o_busy    = (state_q != IDLE);
        o_found   = o_valid && found;
        o_centerX = o_found ? rep_x : '0;
        o_centerY = o_found ? rep_y : '0;
    end

endmodule

// File: tb/tb_point_scan_ctrl.sv
// Directed bench for point_scan_ctrl. Lines carry only as many pixels as the
// runs on them need (line_start restarts x); the last line is full width so
// the frame-end pixel is reached quickly.
module tb_point_scan_ctrl;

    localparam int H = 640;
    localparam int V = 480;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       i_frame_start = 1'b0;
    logic       i_line_start = 1'b0;
    logic       i_pix_valid = 1'b0;
    logic       i_pix_hit = 1'b0;
    logic       i_ready = 1'b0;
    logic       o_valid;
    logic       o_found;
    logic [9:0] o_centerX;
    logic [8:0] o_centerY;
    logic       o_busy;

    int checks = 0;
    int errors = 0;

    point_scan_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .i_frame_start(i_frame_start),
        .i_line_start (i_line_start),
        .i_pix_valid  (i_pix_valid),
        .i_pix_hit    (i_pix_hit),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_found      (o_found),
        .o_centerX    (o_centerX),
        .o_centerY    (o_centerY),
        .o_busy       (o_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        i_pix_valid   = 1'b0;
        i_frame_start = 1'b0;
        i_line_start  = 1'b0;
        i_pix_hit     = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
        i_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Up to three runs (y, lo, hi); y = -1 disables. Lines 0..stop_y-1 are driven.
    task automatic run_frame(input int y0, input int l0, input int h0,
                             input int y1, input int l1, input int h1,
                             input int y2, input int l2, input int h2,
                             input int stop_y, input bit mid_chk);
        for (int y = 0; y < stop_y; y++) begin
            int len;
            len = (y == V - 1) ? H : 1;
            if (y == y0 && h0 + 1 > len) len = h0 + 1;
            if (y == y1 && h1 + 1 > len) len = h1 + 1;
            if (y == y2 && h2 + 1 > len) len = h2 + 1;
            if (len > H) len = H;
            for (int x = 0; x < len; x++) begin
                bit hit;
                hit = (y == y0 && x >= l0 && x <= h0) || (y == y1 && x >= l1 && x <= h1) ||
                      (y == y2 && x >= l2 && x <= h2);
                @(negedge clk);
                if (mid_chk && y == V - 1 && x == 0) begin
                    chk("mid_valid", o_valid, 0);
                    chk("mid_busy", o_busy, 1);
                end
                i_pix_valid   = 1'b1;
                i_frame_start = (y == 0 && x == 0);
                i_line_start  = (x == 0);
                i_pix_hit     = hit;
                if (hit && (x % 2 == 0)) begin
                    // Unqualified cycle inside a run must be ignored.
                    @(negedge clk);
                    i_pix_valid   = 1'b0;
                    i_frame_start = 1'b0;
                    i_line_start  = 1'b0;
                    i_pix_hit     = 1'b1;
                end
            end
        end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic expect_report(input string tag, input bit f, input int ex, input int ey);
        chk({tag, "_valid"}, o_valid, 1);
        chk({tag, "_found"}, o_found, f);
        chk({tag, "_x"}, o_centerX, ex);
        chk({tag, "_y"}, o_centerY, ey);
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
        chk({tag, "_done"}, o_valid, 0);
        chk({tag, "_idle"}, o_busy, 0);
    endtask

    initial begin
        #1;
        chk("rst_valid", o_valid, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_found", o_found, 0);
        chk("rst_x", o_centerX, 0);
        chk("rst_y", o_centerY, 0);
        @(negedge clk);
        rst = 1'b1;

        // Single run x=100..119 on y=50.
        do_reset();
        run_frame(50, 100, 119, -1, 0, 0, -1, 0, 0, V, 1'b1);
        expect_report("t1", 1'b1, 110, 50);

        // Equal widths: earliest run wins.
        do_reset();
        run_frame(10, 0, 19, 200, 300, 319, -1, 0, 0, V, 1'b1);
        expect_report("t2", 1'b1, 10, 10);

        // Only single-pixel runs, including the very last pixel.
        do_reset();
        run_frame(5, 3, 3, 5, 7, 7, V - 1, H - 1, H - 1, V, 1'b1);
        expect_report("t3", 1'b0, 0, 0);

        // Width exactly MIN_WIDTH qualifies.
        do_reset();
        run_frame(7, 4, 5, -1, 0, 0, -1, 0, 0, V, 1'b1);
        expect_report("t3b", 1'b1, 5, 7);

        // Run to end of line must not merge with x=0 hits on the next line.
        do_reset();
        run_frame(20, 630, 639, 21, 0, 1, -1, 0, 0, V, 1'b1);
        expect_report("t4", 1'b1, 635, 20);

        // Full-width run on the last line closes with the frame-end pixel.
        do_reset();
        run_frame(V - 1, 0, H - 1, -1, 0, 0, -1, 0, 0, V, 1'b1);
        expect_report("t4b", 1'b1, 320, V - 1);

        // Report held while a whole frame arrives; that frame is dropped.
        do_reset();
        run_frame(100, 10, 13, -1, 0, 0, -1, 0, 0, V, 1'b1);
        for (int i = 0; i < 50; i++) @(negedge clk);
        chk("t5_hold50_x", o_centerX, 12);
        run_frame(0, 0, 99, -1, 0, 0, -1, 0, 0, V, 1'b0);
        chk("t5_hold_y", o_centerY, 100);
        expect_report("t5a", 1'b1, 12, 100);
        for (int i = 0; i < 20; i++) @(negedge clk);
        chk("t5_dropped", o_valid, 0);
        run_frame(3, 20, 29, -1, 0, 0, -1, 0, 0, V, 1'b1);
        expect_report("t5b", 1'b1, 25, 3);

        // Frame start mid-scan aborts and clears the wider earlier run.
        do_reset();
        run_frame(40, 0, 199, -1, 0, 0, -1, 0, 0, 45, 1'b0);
        chk("abort_busy", o_busy, 1);
        run_frame(60, 50, 53, -1, 0, 0, -1, 0, 0, V, 1'b1);
        expect_report("abort", 1'b1, 52, 60);

        // Reset mid-frame: no partial report.
        do_reset();
        run_frame(10, 0, 49, -1, 0, 0, -1, 0, 0, 20, 1'b0);
        #2 rst = 1'b0;
        #1;
        chk("mrst_busy", o_busy, 0);
        chk("mrst_valid", o_valid, 0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) @(negedge clk);
        chk("mrst_none", o_valid, 0);

        // Consecutive frames: X=100 then X=200, then reset and X=200.
        do_reset();
        run_frame(1, 90, 109, -1, 0, 0, -1, 0, 0, V, 1'b1);
        expect_report("s1", 1'b1, 100, 1);
        run_frame(3, 7, 7, -1, 0, 0, -1, 0, 0, V, 1'b1);
        expect_report("s_nf", 1'b0, 0, 0);
        run_frame(1, 190, 209, -1, 0, 0, -1, 0, 0, V, 1'b1);
`ifdef PSC_SMOOTH_EN
        expect_report("s2", 1'b1, 150, 1);
`else
        expect_report("s2", 1'b1, 200, 1);
`endif
        do_reset();
        run_frame(1, 190, 209, -1, 0, 0, -1, 0, 0, V, 1'b1);
        expect_report("s3", 1'b1, 200, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
